// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU shift-add, DIV/DIVU restoring, plus MTHI/MTLO.
// Result in HI/LO WIDTH+1 cycles after accept, MTHI/MTLO in 1 cycle; no queueing, start ignored while busy, abort flushes.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [5:0]       i_func,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam int         CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_hi;
    logic               neg_lo;

    logic               go;
    logic               op_mul;
    logic               op_div;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic               no_borrow;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] step_next;

    assign o_busy    = (state != IDLE);
    assign go        = i_start && !i_abort;
    assign op_mul    = (i_func == F_MULT) || (i_func == F_MULTU);
    assign op_div    = (i_func == F_DIV)  || (i_func == F_DIVU);
    assign op_signed = (i_func == F_MULT) || (i_func == F_DIV);
    assign a_mag     = (op_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign b_mag     = (op_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign rem_sh    = acc[2*WIDTH-1:WIDTH-1];
    assign no_borrow = (rem_sh >= {1'b0, opnd});
    assign rem_sub   = rem_sh[WIDTH-1:0] - opnd;

    always_comb begin
        step_next = acc;
        if (is_div) begin
            if (no_borrow) step_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
            else           step_next = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0]) step_next = {add_sum, acc[WIDTH-1:1]};
            else        step_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
            o_done <= 1'b0;
            o_hi   <= '0;
            o_lo   <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go && op_mul) begin
                        state  <= RUN;
                        cnt    <= '0;
                        is_div <= 1'b0;
                        acc    <= {{WIDTH{1'b0}}, b_mag};
                        opnd   <= a_mag;
                        neg_lo <= op_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        neg_hi <= 1'b0;
                    end else if (go && op_div) begin
                        state  <= RUN;
                        cnt    <= '0;
                        is_div <= 1'b1;
                        opnd   <= b_mag;
                        // Zero divisor: raw dividend runs through, giving HI=a, LO=all ones.
                        if (i_b == '0) begin
                            acc    <= {{WIDTH{1'b0}}, i_a};
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                        end else begin
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            neg_lo <= op_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                            neg_hi <= op_signed && i_a[WIDTH-1];
                        end
                    end else if (go && i_func == F_MTHI) begin
                        o_hi <= i_a;
                    end else if (go && i_func == F_MTLO) begin
                        o_lo <= i_a;
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        state <= IDLE;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH-1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!i_abort) begin
                        o_done <= 1'b1;
                        if (is_div) begin
                            o_hi <= neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                            o_lo <= neg_lo ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
                        end else begin
                            {o_hi, o_lo} <= neg_lo ? -acc : acc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit that succeeds the single-cycle ALU function decode with a multi-cycle HI/LO datapath. It decodes the R-type function field for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It runs one shift-add or restoring-division step per cycle and holds the HI/LO architectural registers. It sits beside the ALU in the execute stage; the pipeline stalls on `o_busy` and reads HI/LO directly for MFHI/MFLO.

## Interface
- `WIDTH`, 32, operand/HI/LO width; must be even and ≥ 4.
- `i_clk` in 1: single clock, all state changes on its rising edge.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_start` in 1: request; sampled only in IDLE.
- `i_func` in 6: R-type function field. The block decodes 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO; every other value is ignored.
- `i_a` in WIDTH: rs operand (multiplicand/dividend; MTHI/MTLO source).
- `i_b` in WIDTH: rt operand (multiplier/divisor).
- `i_abort` in 1: flush (exception/branch squash); cancels any operation in progress.
- `o_busy` out 1: high in RUN and FIX states.
- `o_done` out 1: registered one-cycle pulse when HI/LO receive a mult/div result.
- `o_hi` out WIDTH: HI register.
- `o_lo` out WIDTH: LO register.

## Operation
- States:
  - IDLE: start accepted here.
  - RUN: WIDTH iterations, driven by a step counter.
  - FIX: sign correction and HI/LO write.
- IDLE → RUN: on `i_start`=1, `i_abort`=0 and `i_func` ∈ {MULT, MULTU, DIV, DIVU}.
  - Operands are latched. For signed ops, the latched values are magnitudes; result sign flags are saved (product: a⊕b; quotient: a⊕b; remainder: sign of a).
- MTHI/MTLO: in IDLE with `i_start`=1 and `i_abort`=0, HI (or LO) ← `i_a` at that edge. The state stays IDLE and `o_done` stays 0.
- RUN:
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per step.
  - After WIDTH steps the state goes to FIX.
- FIX: {HI,LO} ← product, or HI ← remainder and LO ← quotient, each negated per its sign flag. Then `o_done` ← 1 and the state returns to IDLE.
- Divide by zero (DIV or DIVU, b=0): LO ← all ones, HI ← raw `i_a` (no sign correction).
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - −2^(W−1) ÷ −1 gives LO=0x80000000 and HI=0 (for W=32).
- `i_start` in RUN or FIX is ignored; there is no queueing.
- `i_abort` in RUN or FIX: the state goes to IDLE at that edge. HI/LO are unchanged and `o_done` stays 0.
- `i_abort` and `i_start` together in IDLE: abort wins, nothing is accepted, and no MTHI/MTLO write occurs.
- Reset (`i_rst_n`=0 at an edge, in any state): state=IDLE, `o_hi`=0, `o_lo`=0, `o_done`=0, counter=0, `o_busy`=0. A running operation is discarded.

## Timing
- Accept edge E0: `o_busy` rises after E0.
- RUN steps occur on E1…E_WIDTH. FIX writes on E_(WIDTH+1).
- After E_(WIDTH+1):
  - `o_hi`/`o_lo` hold the new result.
  - `o_done`=1 for exactly one cycle.
  - `o_busy`=0.
- Total latency: the result is visible WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
- A new `i_start` is accepted at E_(WIDTH+2), the same cycle `o_done` is high, giving back-to-back throughput of one op per WIDTH+2 cycles.
- MTHI/MTLO: the value is visible on `o_hi`/`o_lo` after the accepting edge, i.e. 1 cycle.
- `o_busy` is combinational from the state register. `o_done`, `o_hi` and `o_lo` are registered.
- Abort latency: `o_busy` falls after the edge sampling `i_abort`=1. A start is accepted at the next edge.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - HI=0xFFFFFFFE, LO=0x00000001.
  - `o_done` high only in the cycle after edge E0+33.
  - `o_busy` high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Follow back-to-back with DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=5, b=0 → LO=0xFFFFFFFF, HI=5.
- Abort cases:
  - MTHI a=0x12345678, then MULTU a=3, b=4 with `i_abort` at step 10 → HI stays 0x12345678, LO unchanged, no `o_done`.
  - Next-cycle MTLO a=7 → LO=7.
  - A second `i_start` issued mid-RUN is ignored.
- Reset mid-run:
  - Assert `i_rst_n`=0 at step 20 of DIVU → HI=LO=0, `o_busy`=0 and no `o_done` afterwards.
  - `i_start` with `i_func`=100000 (ADD) → no state change.
